// File: rtl/ram_scan_reader.sv
// Read-side scanner for the board RAM: sweeps every address, holds each word
// for display, and counts the words equal to a target nibble over each pass.
module ram_scan_reader #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int RD_LATENCY = 1
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  input  logic              i_run,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_target,
  input  logic              i_clear_stats,
  input  logic [DATA_W-1:0] i_rd_q,
  output logic [ADDR_W-1:0] o_rd_address,
  output logic [ADDR_W-1:0] o_disp_address,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  output logic [ADDR_W:0]   o_match_count,
  output logic              o_pass_done,
  output logic              o_busy
);

  localparam int                CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [1:0]        WAIT_LAST = 2'(RD_LATENCY - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {S_ADDR, S_WAIT, S_CAPT, S_HOLD} state_t;

  state_t            r_state;
  logic [1:0]        r_wait;
  logic [CNT_W-1:0]  r_tick;
  logic [ADDR_W-1:0] r_rd_address;
  logic [ADDR_W-1:0] r_disp_address;
  logic [DATA_W-1:0] r_disp_data;
  logic              r_disp_valid;
  logic [ADDR_W:0]   r_acc;
  logic [ADDR_W:0]   r_match_count;
  logic              r_pass_done;
  logic              r_busy;

  logic              w_hit;
  logic [ADDR_W:0]   w_sum;
  logic              w_last;
  logic              w_advance;

  assign w_hit  = (i_rd_q == i_target);
  assign w_sum  = r_acc + {{ADDR_W{1'b0}}, w_hit};
  assign w_last = (r_rd_address == LAST_ADDR);
  // In run mode only the tick advances; a step counts only while stopped.
  assign w_advance = i_run ? (r_tick == TICK_LAST) : i_step;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state        <= S_ADDR;
      r_wait         <= '0;
      r_tick         <= '0;
      r_rd_address   <= '0;
      r_disp_address <= '0;
      r_disp_data    <= '0;
      r_disp_valid   <= 1'b0;
      r_acc          <= '0;
      r_match_count  <= '0;
      r_pass_done    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_pass_done <= 1'b0;
      case (r_state)
        S_ADDR: begin
          r_wait  <= '0;
          r_busy  <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == WAIT_LAST) r_state <= S_CAPT;
          else                     r_wait  <= r_wait + 2'd1;
        end
        S_CAPT: begin
          r_disp_data    <= i_rd_q;
          r_disp_address <= r_rd_address;
          r_disp_valid   <= 1'b1;
          r_tick         <= '0;
          r_busy         <= 1'b0;
          r_state        <= S_HOLD;
          if (w_last) begin
            r_match_count <= w_sum;
            r_acc         <= '0;
            r_pass_done   <= 1'b1;
          end else begin
            r_acc <= w_sum;
          end
        end
        default: begin
          if (w_advance) begin
            r_rd_address <= r_rd_address + 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_ADDR;
          end else if (i_run) begin
            r_tick <= r_tick + CNT_W'(1);
          end
        end
      endcase
      // Clearing overrides any accumulator/result update from a capture on the same edge.
      if (i_clear_stats) begin
        r_acc         <= '0;
        r_match_count <= '0;
      end
    end
  end

  assign o_rd_address   = r_rd_address;
  assign o_disp_address = r_disp_address;
  assign o_disp_data    = r_disp_data;
  assign o_disp_valid   = r_disp_valid;
  assign o_match_count  = r_match_count;
  assign o_pass_done    = r_pass_done;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Scoreboard bench for ram_scan_reader: stimulus queues expected captures,
// a negedge monitor pops and compares them as the DUT presents each word.
module tb_ram_scan_reader;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run, step, clear_stats;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] rd_address, disp_address;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid, pass_done, busy;
  logic [ADDR_W:0]   match_count;

  ram_scan_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TICK_DIV(4), .RD_LATENCY(1)) dut (
    .i_clock(clk), .i_resetn(rst_n), .i_run(run), .i_step(step), .i_target(target),
    .i_clear_stats(clear_stats), .i_rd_q(rd_q), .o_rd_address(rd_address),
    .o_disp_address(disp_address), .o_disp_data(disp_data), .o_disp_valid(disp_valid),
    .o_match_count(match_count), .o_pass_done(pass_done), .o_busy(busy)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) rd_q <= mem[rd_address];

  typedef struct {
    int addr;
    int data;
    bit pass;
    int match;
    int gap;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int model_acc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected captures for addresses lo..hi; target is tgt_a up to address sw, tgt_b after.
  task automatic push_pass(input int lo, input int hi, input int tgt_a, input int tgt_b,
                           input int sw, input bit clr_last, input int first_gap);
    for (int a = lo; a <= hi; a++) begin
      exp_t e;
      int t, hit;
      t = (a <= sw) ? tgt_a : tgt_b;
      hit = (int'(mem[a]) == t) ? 1 : 0;
      e.addr = a;
      e.data = int'(mem[a]);
      e.gap  = (a == lo) ? first_gap : 7;
      e.pass = (a == DEPTH - 1);
      e.match = 0;
      if (a == DEPTH - 1) begin
        e.match = clr_last ? 0 : model_acc + hit;
        model_acc = 0;
      end else begin
        model_acc += hit;
      end
      sb.push_back(e);
    end
  endtask

  // Monitor: a falling busy marks a capture edge.
  bit   prev_busy = 1'b0;
  int   last_cap  = -1;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      last_cap  = -1;
    end else begin
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_capture: got address %0d, expected no capture", disp_address);
        end else begin
          mon_e = sb.pop_front();
          chk("disp_address", int'(disp_address), mon_e.addr);
          chk("disp_data", int'(disp_data), mon_e.data);
          chk("disp_valid", int'(disp_valid), 1);
          chk("pass_done", int'(pass_done), int'(mon_e.pass));
          if (mon_e.pass) chk("match_count", int'(match_count), mon_e.match);
          if (mon_e.gap != 0 && last_cap >= 0) chk("capture_gap", cyc - last_cap, mon_e.gap);
          $display("capture addr=%0d data=%0d pass_done=%0d match=%0d", disp_address, disp_data,
                   pass_done, match_count);
        end
        last_cap = cyc;
      end else if (pass_done) begin
        n_checks++;
        n_err++;
        $display("FAIL stray_pass_done: got 1, expected 0 (cycle %0d)", cyc);
      end
      prev_busy = busy;
    end
  end

  task automatic wait_pass(input string name);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (pass_done) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_addr(input int a);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (int'(disp_address) == a && !busy) return;
    end
    chk("wait_addr_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_address"}, int'(rd_address), 0);
    chk({tag, "_disp_address"}, int'(disp_address), 0);
    chk({tag, "_disp_data"}, int'(disp_data), 0);
    chk({tag, "_disp_valid"}, int'(disp_valid), 0);
    chk({tag, "_match_count"}, int'(match_count), 0);
    chk({tag, "_pass_done"}, int'(pass_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0; clear_stats = 1'b0; target = '0;
    for (int a = 0; a < DEPTH; a++) mem[a] = DATA_W'(a);

    // Reset with random inputs
    repeat (5) begin
      @(negedge clk);
      run = 1'($urandom); step = 1'($urandom); clear_stats = 1'($urandom);
      target = DATA_W'($urandom);
    end
    chk_all_zero("reset");

    // Release stopped: address 0 is read once, then nothing moves
    run = 1'b0; step = 1'b0; clear_stats = 1'b0; target = '0;
    model_acc = 0;
    push_pass(0, 0, 0, 0, 31, 1'b0, 0);
    rst_n = 1'b1;
    #1 chk("release_valid", int'(disp_valid), 0);
    repeat (110) @(negedge clk);
    chk("idle_queue_empty", sb.size(), 0);
    chk("idle_rd_address", int'(rd_address), 0);
    chk("idle_disp_valid", int'(disp_valid), 1);
    chk("idle_busy", int'(busy), 0);

    // Step mode: addresses 1..5; a step during S_WAIT after the 5th is ignored
    for (int s = 1; s <= 5; s++) begin
      push_pass(s, s, 0, 0, 31, 1'b0, 0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      if (s == 5) begin
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
      end
      repeat (19) @(negedge clk);
      chk("step_rd_address", int'(rd_address), s);
    end
    chk("step_queue_empty", sb.size(), 0);

    // Clear the partial pass (address 0 matched target 0)
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk("clear_match_count", int'(match_count), 0);

    // Free run with mem[a] = a % 3
    for (int a = 0; a < DEPTH; a++) mem[a] = DATA_W'(a % 3);
    target = 4'd1;
    model_acc = 0;
    push_pass(6, 31, 1, 1, 31, 1'b0, 0);   // partial pass A
    push_pass(0, 31, 1, 1, 31, 1'b0, 7);   // pass B
    push_pass(0, 31, 1, 0, 20, 1'b0, 7);   // pass C, target -> 0 after address 20
    push_pass(0, 31, 0, 0, 31, 1'b1, 7);   // pass D, clear collides with last capture
    push_pass(0, 31, 0, 0, 31, 1'b0, 7);   // pass E
    push_pass(0, 16, 0, 0, 31, 1'b0, 7);   // pass F, aborted by reset
    run = 1'b1;
    wait_pass("pass_A");
    chk("match_A", int'(match_count), 9);
    wait_pass("pass_B");
    chk("match_B", int'(match_count), 11);
    wait_addr(20);
    target = 4'd0;
    wait_pass("pass_C");
    chk("match_C", int'(match_count), 11);

    wait_addr(30);
    repeat (6) @(negedge clk);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk("collide_pass_done", int'(pass_done), 1);
    chk("collide_match", int'(match_count), 0);
    wait_pass("pass_E");
    chk("match_E", int'(match_count), 11);

    // Reset while address 17 is in S_WAIT
    wait_addr(16);
    repeat (5) @(negedge clk);
    chk("pre_reset_rd_address", int'(rd_address), 17);
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1 chk_all_zero("midop");
    chk("midop_queue_empty", sb.size(), 0);
    repeat (3) @(negedge clk);
    model_acc = 0;
    push_pass(0, 3, 0, 0, 31, 1'b0, 0);
    rst_n = 1'b1;
    wait_addr(3);
    run = 1'b0;
    repeat (20) @(negedge clk);
    chk("final_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end
endmodule
